// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and unified memory, stalling on a mem_req/mem_ready handshake.
module mips_multicycle_controller #(
    parameter int OPC_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCEn,
    output logic             Branch,
    output logic [1:0]       PCSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             RegDst,
    output logic             MemToReg,
    output logic             RegWrite,
    output logic             instr_done,
    output logic             illegal_op
);

    localparam logic [OPC_W-1:0] OP_RTYPE = OPC_W'(6'b000000);
    localparam logic [OPC_W-1:0] OP_LW    = OPC_W'(6'b100011);
    localparam logic [OPC_W-1:0] OP_SW    = OPC_W'(6'b101011);
    localparam logic [OPC_W-1:0] OP_BEQ   = OPC_W'(6'b000100);
    localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'(6'b001000);
    localparam logic [OPC_W-1:0] OP_J     = OPC_W'(6'b000010);

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       fetch;
        logic       jump;
        logic       branch;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       done;
        logic       done_on_ready;
        logic       decode;
    } ctl_t;

    state_t state_q, state_d;
    ctl_t   ctl_q;
    logic   is_sw_q;
    logic   op_legal;

    // Moore part of the outputs, registered by decoding the next state.
    function automatic ctl_t ctl_of(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            FETCH:    begin c.mem_req = 1'b1; c.fetch = 1'b1; c.alu_src_b = 2'b01; end
            DECODE:   begin c.alu_src_b = 2'b11; c.decode = 1'b1; end
            MEMADR:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            MEMRD:    begin c.mem_req = 1'b1; c.iord = 1'b1; end
            MEMWB:    begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.done = 1'b1; end
            MEMWR:    begin
                c.mem_req = 1'b1; c.mem_write = 1'b1; c.iord = 1'b1; c.done_on_ready = 1'b1;
            end
            EXECUTE:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            ALUWB:    begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.done = 1'b1; end
            BRANCH:   begin
                c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.branch = 1'b1;
                c.pc_src = 2'b01; c.done = 1'b1;
            end
            ADDIEXEC: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            ADDIWB:   begin c.reg_write = 1'b1; c.done = 1'b1; end
            JUMP:     begin c.pc_src = 2'b10; c.jump = 1'b1; c.done = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        op_legal = 1'b1;
        case (opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
            default:                                       op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:     state_d = FETCH;
            FETCH:    state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEXEC;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = is_sw_q ? MEMWR : MEMRD;
            MEMRD:    state_d = mem_ready ? MEMWB : MEMRD;
            MEMWB:    state_d = FETCH;
            MEMWR:    state_d = mem_ready ? FETCH : MEMWR;
            EXECUTE:  state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
            ADDIEXEC: state_d = ADDIWB;
            ADDIWB:   state_d = FETCH;
            JUMP:     state_d = FETCH;
            default:  state_d = IDLE;
        endcase
    end

    // lw/sw is remembered from DECODE so MEMADR ignores later opcode changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ctl_q   <= '0;
            is_sw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_of(state_d);
            if (state_q == DECODE) is_sw_q <= (opcode == OP_SW);
        end
    end

    assign mem_req    = ctl_q.mem_req;
    assign MemWrite   = ctl_q.mem_write;
    assign IorD       = ctl_q.iord;
    assign IRWrite    = ctl_q.fetch & mem_ready;
    assign PCWrite    = (ctl_q.fetch & mem_ready) | ctl_q.jump;
    assign PCEn       = PCWrite | (ctl_q.branch & zero);
    assign Branch     = ctl_q.branch;
    assign PCSrc      = ctl_q.pc_src;
    assign ALUSrcA    = ctl_q.alu_src_a;
    assign ALUSrcB    = ctl_q.alu_src_b;
    assign ALUOp      = ctl_q.alu_op;
    assign RegDst     = ctl_q.reg_dst;
    assign MemToReg   = ctl_q.mem_to_reg;
    assign RegWrite   = ctl_q.reg_write;
    assign illegal_op = ctl_q.decode & ~op_legal;
    assign instr_done = ctl_q.done | (ctl_q.done_on_ready & mem_ready) | illegal_op;

endmodule
